// File: rtl/ff_conv_pkg.sv
// Shared direction constants and modulo next-count helper for the T-flip-flop counter.
package ff_conv_pkg;

   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DN = 1'b0;

   localparam int unsigned CNT_MAX_W = 16;

   // Modulo step; out-of-range values go to 0 upward and to q-1 downward.
   function automatic logic [CNT_MAX_W-1:0] next_count(
      input logic [CNT_MAX_W-1:0] q,
      input logic                 up,
      input logic [CNT_MAX_W:0]   mod
   );
      logic [CNT_MAX_W:0] q_ext;
      q_ext = {1'b0, q};
      if (up == DIR_UP) begin
         if (q_ext >= mod - 17'd1) return '0;
         else                      return q + 16'd1;
      end else begin
         if (q == 16'd0) return 16'(mod - 17'd1);
         else            return q - 16'd1;
      end
   endfunction

endpackage

// File: rtl/t_ff_cell.sv
// Single T flip-flop state cell with synchronous active-high reset.
module t_ff_cell (
   input  logic clk,
   input  logic rst,
   input  logic t,
   output logic q
);

   always_ff @(posedge clk) begin
      if (rst)    q <= 1'b0;
      else if (t) q <= ~q;
   end

endmodule

// File: rtl/tff_updn_counter.sv
// Modulo up/down counter built from T flip-flop cells driven by toggle enables.
// Optional parallel load (load, d ports) when TFF_CNT_LOAD_EN is defined.
module tff_updn_counter #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned MOD   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
`ifdef TFF_CNT_LOAD_EN
   input  logic             load,
   input  logic [WIDTH-1:0] d,
`endif
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             wrap
);

   import ff_conv_pkg::*;

   localparam int unsigned MAX = MOD - 1;

   logic             load_i;
   logic [WIDTH-1:0] d_i;
   logic [WIDTH-1:0] next_q;
   logic [WIDTH-1:0] t;

`ifdef TFF_CNT_LOAD_EN
   assign load_i = load;
   assign d_i    = d;
`else
   assign load_i = 1'b0;
   assign d_i    = '0;
`endif

   assign next_q = WIDTH'(next_count(16'(q), up, 17'(MOD)));

   // Target value reaches the cells only as toggle enables; load beats count.
   always_comb begin
      t = '0;
      if (load_i)  t = q ^ d_i;
      else if (en) t = q ^ next_q;
   end

   assign tc = en & (((up == DIR_UP) & (q == WIDTH'(MAX))) |
                     ((up == DIR_DN) & (q == '0)));

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      t_ff_cell u_cell (
         .clk (clk),
         .rst (rst),
         .t   (t[i]),
         .q   (q[i])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) wrap <= 1'b0;
      else     wrap <= tc & ~load_i;
   end

endmodule

// File: tb/tb_tff_updn_counter.sv
// Directed self-checking bench for tff_updn_counter (WIDTH=4, MOD=10).
// Load scenarios run only when TFF_CNT_LOAD_EN is defined.
module tb_tff_updn_counter;

   localparam int unsigned WIDTH = 4;
   localparam int unsigned MOD   = 10;

   logic             clk = 1'b0;
   logic             rst;
   logic             en;
   logic             up;
`ifdef TFF_CNT_LOAD_EN
   logic             load;
   logic [WIDTH-1:0] d;
`endif
   logic [WIDTH-1:0] q;
   logic             tc;
   logic             wrap;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   tff_updn_counter #(.WIDTH(WIDTH), .MOD(MOD)) dut (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .up   (up),
`ifdef TFF_CNT_LOAD_EN
      .load (load),
      .d    (d),
`endif
      .q    (q),
      .tc   (tc),
      .wrap (wrap)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; en = 1'b0; up = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (q !== 4'd0) begin errors++; $display("FAIL reset_q: got %0d want 0", q); end
      checks++;
      if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %b want 0", wrap); end
      checks++;
      if (tc !== 1'b0) begin errors++; $display("FAIL reset_tc_idle: got %b want 0", tc); end
   endtask

   task automatic test_count_up();
      logic [WIDTH-1:0] exp_q;
      do_reset();
      en = 1'b1; up = 1'b1;
      #1;
      checks++;
      if (tc !== 1'b0) begin errors++; $display("FAIL up_tc0: got %b want 0", tc); end
      for (int i = 1; i <= 12; i++) begin
         tick();
         exp_q = WIDTH'(i % 10);
         checks++;
         if (q !== exp_q) begin errors++; $display("FAIL up_q step %0d: got %0d want %0d", i, q, exp_q); end
         checks++;
         if (tc !== (exp_q == 4'd9)) begin errors++; $display("FAIL up_tc step %0d: got %b want %b", i, tc, exp_q == 4'd9); end
         checks++;
         if (wrap !== (exp_q == 4'd0)) begin errors++; $display("FAIL up_wrap step %0d: got %b want %b", i, wrap, exp_q == 4'd0); end
      end
   endtask

   task automatic test_count_down();
      logic [WIDTH-1:0] exp_q [3] = '{4'd9, 4'd8, 4'd7};
      do_reset();
      en = 1'b1; up = 1'b0;
      #1;
      checks++;
      if (tc !== 1'b1) begin errors++; $display("FAIL dn_tc_at0: got %b want 1", tc); end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (q !== exp_q[i]) begin errors++; $display("FAIL dn_q step %0d: got %0d want %0d", i, q, exp_q[i]); end
         checks++;
         if (wrap !== (i == 0)) begin errors++; $display("FAIL dn_wrap step %0d: got %b want %b", i, wrap, i == 0); end
         checks++;
         if (tc !== 1'b0) begin errors++; $display("FAIL dn_tc step %0d: got %b want 0", i, tc); end
      end
   endtask

   task automatic test_hold_and_dir();
      do_reset();
      en = 1'b1; up = 1'b1;
      repeat (5) tick();
      checks++;
      if (q !== 4'd5) begin errors++; $display("FAIL hold_pre: got %0d want 5", q); end
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (q !== 4'd5) begin errors++; $display("FAIL hold_q cyc %0d: got %0d want 5", i, q); end
         checks++;
         if (wrap !== 1'b0 || tc !== 1'b0) begin errors++; $display("FAIL hold_flags cyc %0d: got wrap=%b tc=%b want 0 0", i, wrap, tc); end
      end
      en = 1'b1; up = 1'b0;
      tick();
      checks++;
      if (q !== 4'd4 || wrap !== 1'b0) begin errors++; $display("FAIL dir_dn: got q=%0d wrap=%b want 4 0", q, wrap); end
      up = 1'b1;
      tick();
      checks++;
      if (q !== 4'd5 || wrap !== 1'b0) begin errors++; $display("FAIL dir_up: got q=%0d wrap=%b want 5 0", q, wrap); end
   endtask

   task automatic test_mid_reset();
      do_reset();
      en = 1'b1; up = 1'b1;
      repeat (7) tick();
      checks++;
      if (q !== 4'd7) begin errors++; $display("FAIL midrst_pre: got %0d want 7", q); end
      rst = 1'b1;
      tick();
      checks++;
      if (q !== 4'd0 || wrap !== 1'b0) begin errors++; $display("FAIL midrst_q7: got q=%0d wrap=%b want 0 0", q, wrap); end
      rst = 1'b0;
      repeat (9) tick();
      checks++;
      if (q !== 4'd9 || tc !== 1'b1) begin errors++; $display("FAIL midrst_at9: got q=%0d tc=%b want 9 1", q, tc); end
      rst = 1'b1;
      tick();
      checks++;
      if (q !== 4'd0 || wrap !== 1'b0) begin errors++; $display("FAIL midrst_q9: got q=%0d wrap=%b want 0 0", q, wrap); end
      rst = 1'b0;
   endtask

`ifdef TFF_CNT_LOAD_EN
   task automatic test_load();
      do_reset();
      load = 1'b0; d = '0;
      en = 1'b1; up = 1'b1;
      repeat (3) tick();
      load = 1'b1; d = 4'd9;
      tick();
      checks++;
      if (q !== 4'd9 || wrap !== 1'b0) begin errors++; $display("FAIL load9: got q=%0d wrap=%b want 9 0", q, wrap); end
      load = 1'b0;
      #1;
      checks++;
      if (tc !== 1'b1) begin errors++; $display("FAIL load9_tc: got %b want 1", tc); end
      tick();
      checks++;
      if (q !== 4'd0 || wrap !== 1'b1) begin errors++; $display("FAIL load9_next: got q=%0d wrap=%b want 0 1", q, wrap); end
      repeat (9) tick();
      load = 1'b1; d = 4'd4;
      tick();
      checks++;
      if (q !== 4'd4 || wrap !== 1'b0) begin errors++; $display("FAIL load_over_tc: got q=%0d wrap=%b want 4 0", q, wrap); end
      d = 4'd12;
      tick();
      load = 1'b0;
      checks++;
      if (q !== 4'd12) begin errors++; $display("FAIL load12: got %0d want 12", q); end
      #1;
      checks++;
      if (tc !== 1'b0) begin errors++; $display("FAIL load12_tc: got %b want 0", tc); end
      tick();
      checks++;
      if (q !== 4'd0 || wrap !== 1'b0) begin errors++; $display("FAIL load12_up: got q=%0d wrap=%b want 0 0", q, wrap); end
      load = 1'b1;
      tick();
      load = 1'b0; up = 1'b0;
      tick();
      checks++;
      if (q !== 4'd11) begin errors++; $display("FAIL load12_dn: got %0d want 11", q); end
      en = 1'b0; load = 1'b1; d = 4'd3; rst = 1'b1;
      tick();
      checks++;
      if (q !== 4'd0) begin errors++; $display("FAIL rst_over_load: got %0d want 0", q); end
      rst = 1'b0; load = 1'b0;
   endtask
`endif

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; en = 1'b0; up = 1'b1;
`ifdef TFF_CNT_LOAD_EN
      load = 1'b0; d = '0;
`endif
      test_reset();
      test_count_up();
      test_count_down();
      test_hold_and_dir();
      test_mid_reset();
`ifdef TFF_CNT_LOAD_EN
      test_load();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/tff_updn_counter.md
TFF_UPDN_COUNTER -- requirements
Module: tff_updn_counter

Interface
REQ-001 Parameter WIDTH, default 4, counter width in bits (2..16).
REQ-002 Parameter MOD, default 16, count modulus (2..2**WIDTH); legal values 0..MOD-1.
REQ-003 Port clk input 1: single clock; all state updates on its rising edge.
REQ-004 Port rst input 1: synchronous, active-high reset.
REQ-005 Port en input 1: count enable.
REQ-006 Port up input 1: direction, 1 = increment, 0 = decrement.
REQ-007 Port load input 1: parallel-load strobe (present only with macro, REQ-025).
REQ-008 Port d input WIDTH: parallel-load value (present only with macro).
REQ-009 Port q output WIDTH: registered count value.
REQ-010 Port tc output 1: combinational terminal count.
REQ-011 Port wrap output 1: registered one-cycle wrap pulse.

Function
REQ-012 Every state bit SHALL be a T flip-flop cell; the next count SHALL reach the cells only as per-bit toggle enables (T = q XOR next_q), never as a direct D write.
REQ-013 Priority per edge SHALL be rst > load > en > hold.
REQ-014 en=1, up=1: q SHALL become q+1; from MOD-1 it SHALL become 0.
REQ-015 en=1, up=0: q SHALL become q-1; from 0 it SHALL become MOD-1.
REQ-016 en=0, no load: q SHALL hold; all T inputs SHALL be 0.
REQ-017 Count latency SHALL be one cycle: the change is visible on q after the enabling edge.
REQ-018 tc SHALL equal en AND ((up AND q==MOD-1) OR (NOT up AND q==0)), valid in the same cycle.
REQ-019 wrap SHALL be 1 for exactly the one cycle after an edge at which tc was 1 and no load or rst occurred; 0 otherwise.
REQ-020 Changing up while en=1 SHALL take effect at the next edge; no extra hold cycle.
REQ-021 Simultaneous load and en: load SHALL win, and wrap SHALL be 0 on the next cycle.
REQ-022 If q leaves the legal range (only possible via load), the next count SHALL wrap to 0 when up=1, and to q-1 when up=0 and q>=MOD.

Reset
REQ-023 rst=1 at an edge SHALL force q=0 and wrap=0 regardless of en/load, including mid-count.
REQ-024 tc SHALL follow REQ-018 from q=0 after reset (tc=1 when en=1, up=0).

Configuration
REQ-025 Macro TFF_CNT_LOAD_EN: when defined, load and d ports exist, and load=1 SHALL set q=d at the next edge (through toggle enables q XOR d).
REQ-026 Without TFF_CNT_LOAD_EN, load and d ports SHALL be absent and the counter SHALL behave as if load=0.

Structure
REQ-027 The shared package ff_conv_pkg SHALL hold the direction constants DIR_UP=1 and DIR_DN=0 and the function next_count(q, up, mod).
REQ-028 The sub-module t_ff_cell (clk, rst, t, q; synchronous active-high reset to 0) SHALL be instantiated WIDTH times via generate.

Verification (WIDTH=4, MOD=10)
REQ-029 rst=1 for 2 cycles, then en=1 and up=1 for 12 cycles -> q = 1,2,...,9,0,1,2; tc=1 while q=9; wrap=1 for the cycle q=0.
REQ-030 From q=0, up=0 and en=1 -> tc=1 immediately, then q=9,8,7; wrap pulses once when q=9.
REQ-031 With q=5 and en=1, toggle en to 0 for 3 cycles, then up to 0 -> q holds at 5, then 4; no wrap.
REQ-032 With the macro defined, load=1, d=9, en=1, up=1 on the same edge -> q=9 and wrap=0; next edge -> q=0 and wrap=1 after.
REQ-033 Assert rst at q=7 mid-count with en=1 -> q=0 and wrap=0 at the next edge.
REQ-034 With the macro defined, load d=12 (out of range) then count up -> q=12, then 0; count down from 12 -> q=11.
